mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequences each 32-bit MEM-stage load/store over a 16-bit external SRAM as two multi-cycle halfword accesses. Generates the `freeze` that stalls the IF/ID/EX/MEM pipeline registers until the access completes. Returns the assembled load word to the MEM→WB pipeline register. Sits between the MEM stage (ALU result as address, store data, read/write enables) and the SRAM pins.

## Interface
- `ADDR_W`, default 18: SRAM halfword address width.
- `WAIT_CYCLES`, default 2: cycles per halfword phase; legal range ≥1.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_en` in 1: load request from the MEM stage.
- `wr_en` in 1: store request from the MEM stage.
- `address` in 32: byte address (ALU result). Bits [1:0] are ignored.
- `wdata` in 32: store data.
- `rdata` out 32: load result.
- `ready` out 1: access complete, or no access pending.
- `freeze` out 1: pipeline stall, equal to `~ready`.
- `sram_addr` out ADDR_W: SRAM halfword address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: drive enable for the SRAM data bus.
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: SRAM write strobe, active-low.
- `stall_cnt` out 32: count of frozen cycles. Present only under the `MEM_CTRL_STALL_CNT_EN` macro.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - On `rd_en|wr_en`, capture `address[ADDR_W:2]`, `wdata` and the operation, then go to LOW.
  - If both enables are high, the access is a write.
  - On entry to each phase, load the phase counter with WAIT_CYCLES.
- **LOW**
  - `sram_addr = {addr_q, 1'b0}`.
  - For a write: `sram_dq_out = wdata_q[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - The counter decrements each cycle. On the cycle where counter == 1:
    - For a read, latch `sram_dq_in` into `rdata[15:0]`.
    - Go to HIGH.
- **HIGH**
  - Same as LOW, with `sram_addr = {addr_q, 1'b1}` and write data `wdata_q[31:16]`.
  - At the end of the phase, a read latches `rdata[31:16]`, then go to DONE.
- **DONE**
  - `ready = 1` for exactly one cycle. The pipeline advances on this edge.
  - Go to IDLE unconditionally.
  - A request seen in the following IDLE cycle is a new instruction.
- `ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`. This is combinational, so `freeze` rises in the same cycle the request appears.
- Outputs outside LOW/HIGH: `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`.
- `rdata` is registered. It is updated only by reads and holds between reads; writes leave it unchanged.
- Enables that change mid-access are ignored: the operation, address and data are captured in IDLE.

## Timing
- Per access, `freeze` is high for 1 + 2·WAIT_CYCLES cycles; `ready` is high in the next cycle.
  - WAIT_CYCLES=2: `freeze` high for 5 cycles, DONE in cycle 5 counted from the request cycle 0.
- `rdata` holds the full word from the DONE cycle onward, sampled by MEM→WB on the DONE edge.
- Back-to-back accesses: one IDLE cycle between DONE and the next LOW, with `freeze` high throughout.
- Reset values: state IDLE, `rdata = 0`, `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`, `ready = 1` when there is no request, `stall_cnt = 0`.
- Reset asserted mid-access aborts immediately (asynchronously): `sram_we_n` goes to 1 and `sram_dq_oe` to 0 with no clock edge; the partial write is not completed.

## Configuration
- `MEM_CTRL_STALL_CNT_EN` defined:
  - The `stall_cnt` port exists.
  - It increments on every clock where `freeze == 1` and saturates at 32'hFFFF_FFFF.
  - It is cleared only by `rst`.
- `MEM_CTRL_STALL_CNT_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Test plan
- **Read.** WAIT_CYCLES=2. Model returns 16'h5678 at `sram_addr` 0x100 and 16'h1234 at 0x101; `rd_en` with `address` = 32'h0000_0200 held until `ready`.
  - Expect `freeze` high for exactly 5 cycles, `sram_addr` 0x100 for 2 cycles then 0x101 for 2 cycles, and `rdata` = 32'h1234_5678 in DONE.
- **Write.** `wr_en` with `address` = 32'h0000_0204, `wdata` = 32'hDEAD_BEEF.
  - Expect `sram_we_n` low for 4 cycles: 0x102 carries 16'hBEEF, then 0x103 carries 16'hDEAD.
  - Expect `sram_dq_oe` high only in those 4 cycles and `rdata` unchanged.
- **Back-to-back.** Read immediately followed by a write.
  - Expect DONE, IDLE, then LOW, with `freeze` low only in the single DONE cycle.
- **Simultaneous enables and idle.** `rd_en = wr_en = 1` in the same cycle.
  - Expect a write sequence.
  - With both enables low, expect `ready = 1` and `freeze = 0` continuously.
- **Reset mid-write.** Assert `rst` in the second LOW cycle of a write.
  - Expect `sram_we_n = 1` and `sram_dq_oe = 0` with no clock edge, state IDLE, and `rdata = 0`.
- **Stall counter.** With `MEM_CTRL_STALL_CNT_EN` defined, run three reads at WAIT_CYCLES=2.
  - Expect `stall_cnt = 15` after the third DONE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - 32-bit load/store sequencer over a 16-bit SRAM (optional MEM_CTRL_STALL_CNT_EN stall counter)
module mem_access_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
`ifdef MEM_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-2:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt;
  logic              req;
  logic              phase_end;
  logic              unused_addr_bits;

  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == CNT_ONE);

  // Word-aligned byte address: the low two bits and everything above the SRAM range are dropped.
  assign unused_addr_bits = ^{address[31:ADDR_W+1], address[1:0]};

  // State register; an asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: two timed halfword phases, then a single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (phase_end) state_nxt = HIGH;
      HIGH:    if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, phase counter and load-word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= address[ADDR_W:2];
            wdata_q <= wdata;
            wr_q    <= wr_en;
            cnt     <= CNT_LOAD;
          end
        end
        LOW, HIGH: begin
          if (phase_end) begin
            cnt <= CNT_LOAD;
            if (!wr_q) begin
              if (state == LOW) rdata[15:0]  <= sram_dq_in;
              else              rdata[31:16] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  // SRAM pin drive and handshake, decoded from the current state only.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      LOW: begin
        sram_addr = {addr_q, 1'b0};
        if (wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HIGH: begin
        sram_addr = {addr_q, 1'b1};
        if (wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      default: sram_addr = '0;
    endcase
    ready  = (state == DONE) | ((state == IDLE) & ~req);
    freeze = ~ready;
  end

`ifdef MEM_CTRL_STALL_CNT_EN
  // Saturating count of frozen cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_cnt <= '0;
    else if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
